// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: word RAM behind a request FSM that inserts
// WAIT_STATES wait cycles and reports completion via ready/busy/err.
module mem_bus_responder #(
    parameter int unsigned MAX_WIDTH   = 8,
    parameter int unsigned DEPTH       = 200,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAX_WIDTH-1:0] addr_b,
    input  logic [MAX_WIDTH-1:0] wr_data,
    input  logic                 rd_req,
    input  logic                 wr_req,
    output logic [MAX_WIDTH-1:0] rd_data,
    output logic                 ready,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [MAX_WIDTH-1:0] addr_q, addr_nxt;
    logic [MAX_WIDTH-1:0] data_q, data_nxt;
    logic                 is_wr_q, is_wr_nxt;
    logic [MAX_WIDTH-1:0] rd_data_nxt;
    logic                 ready_nxt, busy_nxt, err_nxt;
    logic                 mem_we_c;
    logic                 in_range_c;

    logic [MAX_WIDTH-1:0] mem [DEPTH];

    // Addresses are checked against DEPTH, never folded.
    assign in_range_c = (32'(addr_q) < DEPTH);

    // State and registered outputs; RAM contents are deliberately not reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            is_wr_q <= 1'b0;
            rd_data <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            is_wr_q <= is_wr_nxt;
            rd_data <= rd_data_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
            err     <= err_nxt;
        end
    end

    // Write only happens on the ACCESS exit edge, so a reset aborts it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[AW'(addr_q)] <= data_q;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        is_wr_nxt   = is_wr_q;
        rd_data_nxt = rd_data;
        ready_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        err_nxt     = 1'b0;
        mem_we_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (rd_req ^ wr_req) begin
                    addr_nxt  = addr_b;
                    data_nxt  = wr_data;
                    is_wr_nxt = wr_req;
                    cnt_nxt   = CNT_W'(WAIT_STATES);
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end else if (rd_req && wr_req) begin
                    err_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ready_nxt = 1'b1;
                state_nxt = S_DONE;
                if (in_range_c) begin
                    if (is_wr_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rd_data_nxt = mem[AW'(addr_q)];
                    end
                end else begin
                    err_nxt = 1'b1;
                    if (!is_wr_q) begin
                        rd_data_nxt = '0;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states,
// one with zero wait states, checked against hand-computed values.
module tb_mem_bus_responder;

    logic       clk;
    logic       rst;
    logic [7:0] addr_b;
    logic [7:0] wr_data;
    logic       rd_req, wr_req;
    logic [7:0] rd_data;
    logic       ready, busy, err;

    logic       rd_req1, wr_req1;
    logic [7:0] rd_data1;
    logic       ready1, busy1, err1;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_responder #(.MAX_WIDTH(8), .DEPTH(200), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .addr_b(addr_b), .wr_data(wr_data),
        .rd_req(rd_req), .wr_req(wr_req), .rd_data(rd_data),
        .ready(ready), .busy(busy), .err(err)
    );

    mem_bus_responder #(.MAX_WIDTH(8), .DEPTH(200), .WAIT_STATES(0)) dut0ws (
        .clk(clk), .rst(rst), .addr_b(addr_b), .wr_data(wr_data),
        .rd_req(rd_req1), .wr_req(wr_req1), .rd_data(rd_data1),
        .ready(ready1), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the WAIT_STATES=2 instance; returns data/err seen with ready.
    task automatic op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int lat);
        addr_b  = a;
        wr_data = d;
        rd_req  = !wr;
        wr_req  = wr;
        tick();
        rd_req = 1'b0;
        wr_req = 1'b0;
        check("busy_after_e0", 32'(busy), 32'd1);
        lat = 0;
        while (!ready && lat < 20) begin
            tick();
            lat++;
        end
        rd = rd_data;
        er = err;
        check("latency", 32'(lat), 32'd3);
        tick();
        check("ready_drop", 32'(ready), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
        check("err_drop", 32'(err), 32'd0);
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    logic [5:0] exp_rdy;
    logic [5:0] exp_bsy;

    initial begin
        rst = 1'b0; addr_b = '0; wr_data = '0;
        rd_req = 0; wr_req = 0; rd_req1 = 0; wr_req1 = 0;
        #3;
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        op(1'b1, 8'h10, 8'hA5, rd, er, lat);
        check("wr_keeps_rd_data", 32'(rd), 32'h00);
        check("wr_err", 32'(er), 32'd0);
        op(1'b0, 8'h10, 8'h00, rd, er, lat);
        check("rd_10", 32'(rd), 32'hA5);
        check("rd_10_err", 32'(er), 32'd0);

        // Both requests: error pulse only.
        addr_b = 8'h10; wr_data = 8'hFF; rd_req = 1; wr_req = 1;
        tick();
        rd_req = 0; wr_req = 0;
        check("both_err", 32'(err), 32'd1);
        check("both_ready", 32'(ready), 32'd0);
        check("both_busy", 32'(busy), 32'd0);
        tick();
        check("both_err_clear", 32'(err), 32'd0);
        op(1'b0, 8'h10, 8'h00, rd, er, lat);
        check("both_ram_kept", 32'(rd), 32'hA5);

        // Out of range address.
        op(1'b1, 8'hF0, 8'h33, rd, er, lat);
        check("oor_wr_err", 32'(er), 32'd1);
        check("oor_wr_rd_hold", 32'(rd), 32'hA5);
        op(1'b0, 8'hF0, 8'h00, rd, er, lat);
        check("oor_rd_data", 32'(rd), 32'h00);
        check("oor_rd_err", 32'(er), 32'd1);
        op(1'b0, 8'hC7, 8'h00, rd, er, lat);
        check("last_addr_err", 32'(er), 32'd0);

        op(1'b1, 8'h05, 8'h5A, rd, er, lat);
        op(1'b0, 8'h05, 8'h00, rd, er, lat);
        check("rd_05", 32'(rd), 32'h5A);

        // Reset during WAIT aborts the write.
        addr_b = 8'h05; wr_data = 8'h77; wr_req = 1;
        tick();
        wr_req = 0;
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rd_data", 32'(rd_data), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        check("async_err", 32'(err), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        op(1'b0, 8'h05, 8'h00, rd, er, lat);
        check("rst_abort_wr", 32'(rd), 32'h5A);

        // Bus changes after sampling do not disturb the access.
        op(1'b1, 8'h06, 8'h44, rd, er, lat);
        addr_b = 8'h05; wr_data = 8'h22; wr_req = 1;
        tick();
        wr_req = 0; addr_b = 8'h06; wr_data = 8'h11;
        repeat (5) tick();
        op(1'b0, 8'h05, 8'h00, rd, er, lat);
        check("latched_wr_05", 32'(rd), 32'h22);
        op(1'b0, 8'h06, 8'h00, rd, er, lat);
        check("untouched_06", 32'(rd), 32'h44);

        // Zero wait states, request held across busy.
        addr_b = 8'h10; wr_data = 8'h3C; wr_req1 = 1;
        tick();
        wr_req1 = 0;
        repeat (3) tick();
        rd_req1 = 1;
        tick();
        check("ws0_busy_e0", 32'(busy1), 32'd1);
        check("ws0_ready_e0", 32'(ready1), 32'd0);
        exp_rdy = 6'b001001;
        exp_bsy = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ws0_ready_e%0d", i + 1), 32'(ready1), 32'(exp_rdy[i]));
            check($sformatf("ws0_busy_e%0d", i + 1), 32'(busy1), 32'(exp_bsy[i]));
            if (i == 0) check("ws0_rd_data", 32'(rd_data1), 32'h3C);
        end
        rd_req1 = 0;
        repeat (3) tick();
        check("ws0_idle", 32'(busy1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
